// File: rtl/fd_pkg.sv
// Shared definitions for the fetch/decode stage: FSM states, opcode constants,
// instruction field positions and the illegal-opcode classifier.
package fd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ISSUE,
        EXEC,
        HALT
    } fd_state_t;

    localparam logic [6:0] OP_ADD    = 7'd0;
    localparam logic [6:0] OP_JMP    = 7'd14;
    localparam logic [6:0] OP_JMPF   = 7'd15;
    localparam logic [6:0] OP_HALT   = 7'd127;
    localparam logic [6:0] OP_ILL_LO = 7'd16;
    localparam logic [6:0] OP_ILL_HI = 7'd126;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 25;
    localparam int RD_MSB  = 24;
    localparam int RD_LSB  = 21;
    localparam int RS1_MSB = 20;
    localparam int RS1_LSB = 17;
    localparam int HL_BIT  = 16;
    localparam int VAL_MSB = 15;
    localparam int VAL_LSB = 0;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;

    function automatic logic is_illegal(input logic [6:0] op);
        return (op >= OP_ILL_LO) && (op <= OP_ILL_HI);
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational slicer from a 32-bit instruction word to the ALU-facing fields.
module instr_field_decode
    import fd_pkg::*;
(
    input  logic [31:0] instr,
    output logic [6:0]  dec_instr,
    output logic [3:0]  dec_rd,
    output logic [3:0]  dec_rs1,
    output logic [3:0]  dec_rs2,
    output logic        dec_highlow,
    output logic [15:0] dec_value
);

    // rs2 deliberately overlaps the low nibble of the immediate
    assign dec_instr   = instr[OPC_MSB:OPC_LSB];
    assign dec_rd      = instr[RD_MSB:RD_LSB];
    assign dec_rs1     = instr[RS1_MSB:RS1_LSB];
    assign dec_rs2     = instr[RS2_MSB:RS2_LSB];
    assign dec_highlow = instr[HL_BIT];
    assign dec_value   = instr[VAL_MSB:VAL_LSB];

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: owns the PC, fetches one instruction at a time and issues
// it to the ALU, then waits for the branch result before the next fetch.
//
// state | meaning
// IDLE  | no request; start a fetch when run=1
// REQ   | imem_req held with imem_addr=pc until imem_gnt
// WAIT  | granted; capture imem_rdata on imem_rvalid
// ISSUE | dec_valid presented until alu_ready (illegal ops skip to IDLE)
// EXEC  | waiting for br_valid to choose the next pc
// HALT  | halt opcode executed; only reset leaves
module fetch_decode
    import fd_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter logic [6:0]  HALT_OP  = OP_HALT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              dec_valid,
    input  logic              alu_ready,
    output logic [6:0]        dec_instr,
    output logic [3:0]        dec_rd,
    output logic [3:0]        dec_rs1,
    output logic [3:0]        dec_rs2,
    output logic              dec_highlow,
    output logic [15:0]       dec_value,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              illegal
);

    fd_state_t         state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [6:0]        rdata_op;
    logic [6:0]        ir_op;

    assign rdata_op  = imem_rdata[OPC_MSB:OPC_LSB];
    assign ir_op     = ir[OPC_MSB:OPC_LSB];
    assign imem_addr = pc;
    assign pc_out    = pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= ADDR_W'(RESET_PC);
            ir        <= '0;
            imem_req  <= 1'b0;
            dec_valid <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    // a same-cycle rvalid is ignored; data only counts in WAIT
                    if (imem_gnt) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        ir <= imem_rdata;
                        if (rdata_op == HALT_OP) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            dec_valid <= !is_illegal(rdata_op);
                        end
                        if (is_illegal(rdata_op)) begin
                            illegal <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (is_illegal(ir_op)) begin
                        pc    <= pc + ADDR_W'(4);
                        state <= IDLE;
                    end else if (dec_valid && alu_ready) begin
                        dec_valid <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (br_valid) begin
                        pc    <= br_taken ? (br_target & ~ADDR_W'(3)) : pc + ADDR_W'(4);
                        state <= IDLE;
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    instr_field_decode u_field_decode (
        .instr       (ir),
        .dec_instr   (dec_instr),
        .dec_rd      (dec_rd),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_highlow (dec_highlow),
        .dec_value   (dec_value)
    );

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: table-driven instruction vectors with a
// decode scoreboard, plus hand sequences for illegal, halt and reset corners.
module tb_fetch_decode;

    logic        clock;
    logic        reset;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        alu_ready;
    logic [6:0]  dec_instr;
    logic [3:0]  dec_rd;
    logic [3:0]  dec_rs1;
    logic [3:0]  dec_rs2;
    logic        dec_highlow;
    logic [15:0] dec_value;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc_out;
    logic        halted;
    logic        illegal;

    fetch_decode dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .alu_ready   (alu_ready),
        .dec_instr   (dec_instr),
        .dec_rd      (dec_rd),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_highlow (dec_highlow),
        .dec_value   (dec_value),
        .br_valid    (br_valid),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .pc_out      (pc_out),
        .halted      (halted),
        .illegal     (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] word;
        int          gnt_dly;
        int          rdy_dly;
        logic        taken;
        logic [31:0] target;
        logic        drop_run;
        logic [6:0]  e_instr;
        logic [3:0]  e_rd;
        logic [3:0]  e_rs1;
        logic [3:0]  e_rs2;
        logic        e_hl;
        logic [15:0] e_value;
        logic [31:0] e_next;
    } vec_t;

    typedef struct {
        logic [6:0]  instr;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        hl;
        logic [15:0] value;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[7];
    int          checks   = 0;
    int          failures = 0;
    int          fetch_cnt = 0;
    logic [31:0] m_pc;

    always @(posedge clock) begin
        if (imem_req && imem_gnt) fetch_cnt <= fetch_cnt + 1;
    end

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_req;
        int n = 0;
        while (!imem_req && n < 20) begin
            tick;
            n++;
        end
        chk("req_seen", imem_req, 1);
    endtask

    task automatic do_fetch(input logic [31:0] word, input int gnt_dly, input bit push, input exp_t e);
        int c0;
        wait_req;
        chk("fetch_addr", imem_addr, m_pc);
        c0 = fetch_cnt;
        for (int i = 0; i < gnt_dly; i++) begin
            tick;
            chk("req_hold", imem_req, 1);
            chk("addr_hold", imem_addr, m_pc);
        end
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFE00_0000;
        tick;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        chk("req_drop", imem_req, 0);
        chk("one_fetch", fetch_cnt, c0 + 1);
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        if (push) sb_q.push_back(e);
        tick;
        imem_rvalid = 1'b0;
    endtask

    task automatic do_issue(input vec_t v);
        exp_t e;
        chk("issue_valid", dec_valid, 1);
        chk("issue_pc", pc_out, m_pc);
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual=0 required=1");
        end else begin
            e = sb_q.pop_front();
            chk("dec_instr", dec_instr, e.instr);
            chk("dec_rd", dec_rd, e.rd);
            chk("dec_rs1", dec_rs1, e.rs1);
            chk("dec_rs2", dec_rs2, e.rs2);
            chk("dec_highlow", dec_highlow, e.hl);
            chk("dec_value", dec_value, e.value);
            for (int i = 0; i < v.rdy_dly; i++) begin
                br_valid  = 1'b1;
                br_taken  = 1'b1;
                br_target = 32'hDEAD_BEE0;
                tick;
                chk("stall_valid", dec_valid, 1);
                chk("stall_instr", dec_instr, e.instr);
                chk("stall_value", dec_value, e.value);
            end
        end
        br_valid  = 1'b0;
        alu_ready = 1'b1;
        tick;
        alu_ready = 1'b0;
        chk("accept_drop", dec_valid, 0);
        br_valid  = 1'b1;
        br_taken  = v.taken;
        br_target = v.target;
        tick;
        br_valid  = 1'b0;
        chk("next_pc", pc_out, v.e_next);
        m_pc = v.e_next;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        e = '{v.e_instr, v.e_rd, v.e_rs1, v.e_rs2, v.e_hl, v.e_value};
        do_fetch(v.word, v.gnt_dly, 1'b1, e);
        if (v.drop_run) run = 1'b0;
        do_issue(v);
        if (v.drop_run) begin
            for (int i = 0; i < 4; i++) begin
                tick;
                chk("run_stop", imem_req, 0);
            end
            run = 1'b1;
        end
    endtask

    initial begin
        exp_t        dummy;
        logic        any_req;
        logic [31:0] w;

        //          word          gd rd tk target        drop op    rd    rs1   rs2   hl    value     next
        vecs[0] = '{32'h0A44_0005, 0, 0, 1'b0, 32'h0,        1'b0, 7'd5,  4'd2, 4'd2, 4'd5, 1'b0, 16'h0005, 32'h0000_0004};
        vecs[1] = '{32'h1C63_1234, 0, 0, 1'b1, 32'h0000_0103, 1'b0, 7'd14, 4'd3, 4'd1, 4'd4, 1'b1, 16'h1234, 32'h0000_0100};
        vecs[2] = '{32'h03EE_BEEF, 2, 3, 1'b0, 32'h0,        1'b0, 7'd1,  4'hF, 4'd7, 4'hF, 1'b0, 16'hBEEF, 32'h0000_0104};
        vecs[3] = '{32'h1F35_00A6, 0, 0, 1'b1, 32'hFFFF_FFFF, 1'b1, 7'd15, 4'd9, 4'hA, 4'd6, 1'b1, 16'h00A6, 32'hFFFF_FFFC};
        vecs[4] = '{32'h0024_0003, 1, 1, 1'b0, 32'h0,        1'b0, 7'd0,  4'd1, 4'd2, 4'd3, 1'b0, 16'h0003, 32'h0000_0000};
        vecs[5] = '{32'h0024_0003, 0, 0, 1'b0, 32'h0,        1'b0, 7'd0,  4'd1, 4'd2, 4'd3, 1'b0, 16'h0003, 32'h0000_0008};
        vecs[6] = '{32'h0A44_0005, 0, 2, 1'b0, 32'h0,        1'b0, 7'd5,  4'd2, 4'd2, 4'd5, 1'b0, 16'h0005, 32'h0000_0004};
        dummy = '{7'd0, 4'd0, 4'd0, 4'd0, 1'b0, 16'd0};

        reset = 1'b1; run = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        alu_ready = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_target = '0;
        tick; tick;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", dec_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_instr", dec_instr, 0);
        reset = 1'b0;
        run   = 1'b1;
        m_pc  = 32'h0;

        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // illegal opcode 40 at pc 0: no issue, pc+4, sticky flag
        w = 32'h5000_0000;
        do_fetch(w, 0, 1'b0, dummy);
        chk("ill_novalid", dec_valid, 0);
        chk("ill_flag", illegal, 1);
        tick;
        chk("ill_novalid2", dec_valid, 0);
        chk("ill_pc", pc_out, 32'h4);
        m_pc = 32'h4;
        run_vec(vecs[5]);
        chk("ill_sticky", illegal, 1);

        // halt at pc 8: no further requests
        w = 32'hFE00_0000;
        do_fetch(w, 0, 1'b0, dummy);
        chk("halt_flag", halted, 1);
        chk("halt_novalid", dec_valid, 0);
        any_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            any_req = any_req | imem_req;
        end
        chk("halt_noreq", any_req, 0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("halt_rst", halted, 0);
        chk("ill_rst", illegal, 0);
        chk("rst2_pc", pc_out, 0);
        chk("rst2_value", dec_value, 0);
        m_pc = 32'h0;

        // reset while waiting for data; late rvalid must be ignored
        wait_req;
        chk("rw_addr", imem_addr, 0);
        imem_gnt = 1'b1;
        tick;
        imem_gnt = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0A44_0005;
        tick;
        imem_rvalid = 1'b0;
        chk("rw_novalid", dec_valid, 0);
        chk("rw_noload", dec_instr, 0);
        tick;
        chk("rw_novalid2", dec_valid, 0);
        run_vec(vecs[6]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
